fetch_unit: RTL and testbench
=============================

# fetch_unit

Sequential Y86-64 instruction fetch stage, the producer side of the PC-update interface. It holds the architectural PC register and reads instruction bytes one at a time from a byte-wide instruction memory over a req/ack handshake. It assembles icode, ifun, rA, rB, valC and valP, presents them with `instr_valid`, and then waits for the PC-update stage to return `pc_new` with a `pc_load` pulse.

## Interface
Parameters:
- `RESET_PC`, 64'h0, PC value loaded on reset.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_new`  in  64  next PC from the PC-update stage.
- `pc_load`  in  1  single-cycle pulse: load `pc_new` and start a fetch. Honoured only in DONE.
- `mem_addr`  out  64  byte address of the current request.
- `mem_req`  out  1  memory request.
- `mem_rdata`  in  8  read byte; valid when `mem_ack` is high.
- `mem_ack`  in  1  request complete. May be high in the same cycle as `mem_req` or arrive later.
- `mem_err`  in  1  address fault; sampled with `mem_ack`.
- `pc_val`  out  64  PC of the instruction being fetched or presented.
- `icode`, `ifun`, `rA`, `rB`  out  4 each  decoded fields.
- `valC`  out  64  constant word.
- `valP`  out  64  `pc_val` + instruction length.
- `instr_valid`  out  1  high in DONE; all decode outputs are stable while it is high.
- `instr_invalid`  out  1  icode > 4'hB; qualified by `instr_valid`.
- `imem_error`  out  1  memory fault during this fetch; qualified by `instr_valid`.

## Operation
- States: FETCH, DONE. Reset forces FETCH with `pc_val`=`RESET_PC` and byte index k=0.
- FETCH:
  - `mem_req`=1 and `mem_addr`=`pc_val`+k, held stable until `mem_ack`.
  - On each edge where `mem_req`&&`mem_ack`, byte k is captured and k increments.
- Byte 0 gives icode=byte[7:4] and ifun=byte[3:0]. This sets the length L:
  - 0x0 (halt), 0x1 (nop), 0x9 (ret): L=1.
  - 0x2 (rrmovq/cmovXX), 0x6 (OPq), 0xA (pushq), 0xB (popq): L=2. Byte 1 gives rA=[7:4], rB=[3:0].
  - 0x3, 0x4, 0x5: L=10. Byte 1 gives the registers; bytes 2..9 give valC.
  - 0x7 (jXX), 0x8 (call): L=9. Bytes 1..8 give valC; rA=rB=4'hF.
  - icode > 0xB: L=1, `instr_invalid`=1.
- valC is little-endian: byte j of the constant lands at valC[8j+7:8j]. Unfetched fields are 4'hF for rA/rB and 0 for valC.
- When the last byte (k=L-1) is accepted, the next state is DONE and valP=`pc_val`+L, modulo 2^64.
- Memory fault: if `mem_err` is high with `mem_ack`, `imem_error`=1 and the next state is DONE immediately. valP=`pc_val`+k+1, and fields not yet fetched keep their defaults.
- DONE:
  - `mem_req`=0 and `instr_valid`=1; outputs are held indefinitely.
  - On `pc_load`: `pc_val`←`pc_new`, k←0, all fields cleared to defaults, next state FETCH.
- `pc_load` outside DONE is ignored. There is no queueing.
- Address arithmetic wraps modulo 2^64. Address 64'hFFFF_FFFF_FFFF_FFFF followed by 0 is legal.

## Timing
- Reset values:
  - Control: state FETCH, `mem_req`=1, `mem_addr`=`pc_val`=`RESET_PC`.
  - Decode fields: icode=ifun=0, rA=rB=4'hF, valC=0, valP=`RESET_PC`.
  - Flags: `instr_valid`=`instr_invalid`=`imem_error`=0.
- With zero-wait memory (ack in the same cycle as req), an L-byte instruction takes L cycles in FETCH. `instr_valid` rises on the edge after the last ack.
- Each wait cycle, where `mem_req` is high and `mem_ack` is low, adds one cycle.
- `pc_load` at edge t puts FETCH in effect from cycle t+1, with `mem_addr`=`pc_new`.
- `mem_addr` and `mem_req` are registered or derived only from state. There is no combinational path from `mem_ack` to `mem_addr`.
- Reset asserted mid-fetch aborts the fetch at once (asynchronously). Fetching restarts at `RESET_PC` on the first edge after deassertion.

## Test plan
- Reset release with zero-wait memory, nop (0x10) at address 0 -> one req at addr 0. Next cycle: `instr_valid`=1, icode=1, valP=1, rA=rB=F.
- irmovq bytes 30 F3 01 02 03 04 05 06 07 08 at 0 -> 10 cycles of req at addrs 0..9. Then rA=F, rB=3, valC=64'h0807060504030201, valP=10.
- In DONE, pulse `pc_load` with `pc_new`=64'h100, where memory holds jXX 73 + 8 bytes of 64'h40 -> icode=7, ifun=3, valC=64'h40, valP=64'h109, `pc_val`=64'h100.
- Byte 0xC0 at 0x20 -> `instr_invalid`=1, valP=64'h21, single memory access. A further `pc_load` pulse issued during a subsequent FETCH is ignored.
- rmmovq with `mem_err` on byte 3 plus 2 wait states per byte -> `imem_error`=1, valP=`pc_val`+4. `mem_addr` stays stable through the waits.
- Assert `reset` during byte 5 of a call fetch -> `mem_req` still 1 with addr `RESET_PC` and `instr_valid`=0 immediately. After release, the fetch restarts at byte 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: sequential Y86-64 instruction fetch. Reads one instruction byte
// per memory handshake, assembles the decode fields, presents them in DONE and
// waits for the PC-update stage to hand back the next PC via pc_load.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_FETCH | requesting byte k at pc_val+k, capturing it on each ack
//   S_DONE  | instruction presented (instr_valid), waiting for pc_load
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] pc_new,
  input  logic        pc_load,
  output logic [63:0] mem_addr,
  output logic        mem_req,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  input  logic        mem_err,
  output logic [63:0] pc_val,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instr_valid,
  output logic        instr_invalid,
  output logic        imem_error
);

  typedef enum logic {S_FETCH = 1'b0, S_DONE = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_pc;
  logic [3:0]  r_k;
  logic [3:0]  r_icode;
  logic [3:0]  r_ifun;
  logic [3:0]  r_ra;
  logic [3:0]  r_rb;
  logic [63:0] r_valc;
  logic [63:0] r_valp;
  logic        r_invalid;
  logic        r_err;

  logic        w_accept;
  logic [3:0]  w_icode;
  logic [3:0]  w_len;
  logic        w_last;
  logic        w_has_regs;
  logic        w_valc_en;
  logic [2:0]  w_valc_idx;
  logic [3:0]  w_k_m1;
  logic [3:0]  w_k_m2;

  assign w_accept = (r_state == S_FETCH) && mem_ack;
  // While byte 0 is arriving the opcode is not yet registered, so decode it
  // straight from the bus; afterwards use the captured copy.
  assign w_icode  = (r_k == 4'd0) ? mem_rdata[7:4] : r_icode;
  assign w_last   = (r_k == (w_len - 4'd1));
  assign w_k_m1   = r_k - 4'd1;
  assign w_k_m2   = r_k - 4'd2;

  // Instruction length, register-byte presence and valC byte lane from icode.
  always_comb begin
    w_len      = 4'd1;
    w_has_regs = 1'b0;
    w_valc_en  = 1'b0;
    w_valc_idx = 3'd0;
    case (w_icode)
      4'h2, 4'h6, 4'hA, 4'hB: begin
        w_len      = 4'd2;
        w_has_regs = 1'b1;
      end
      4'h3, 4'h4, 4'h5: begin
        w_len      = 4'd10;
        w_has_regs = 1'b1;
        w_valc_en  = (r_k >= 4'd2);
        w_valc_idx = w_k_m2[2:0];
      end
      4'h7, 4'h8: begin
        w_len      = 4'd9;
        w_valc_en  = (r_k >= 4'd1);
        w_valc_idx = w_k_m1[2:0];
      end
      default: w_len = 4'd1;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_nxt;
  end

  // Next state: leave FETCH on a fault or the final byte; leave DONE on pc_load.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: if (w_accept && (mem_err || w_last)) w_state_nxt = S_DONE;
      S_DONE:  if (pc_load) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // PC, byte index and decode fields.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_k       <= 4'd0;
      r_icode   <= 4'h0;
      r_ifun    <= 4'h0;
      r_ra      <= 4'hF;
      r_rb      <= 4'hF;
      r_valc    <= 64'd0;
      r_valp    <= RESET_PC;
      r_invalid <= 1'b0;
      r_err     <= 1'b0;
    end else if (r_state == S_FETCH) begin
      if (mem_ack) begin
        if (mem_err) begin
          r_err  <= 1'b1;
          r_valp <= r_pc + {60'd0, r_k} + 64'd1;
        end else begin
          r_k <= r_k + 4'd1;
          if (r_k == 4'd0) begin
            r_icode <= mem_rdata[7:4];
            r_ifun  <= mem_rdata[3:0];
          end
          if ((r_k == 4'd1) && w_has_regs) begin
            r_ra <= mem_rdata[7:4];
            r_rb <= mem_rdata[3:0];
          end
          if (w_valc_en) r_valc[{w_valc_idx, 3'b000} +: 8] <= mem_rdata;
          if (w_last) begin
            r_valp    <= r_pc + {60'd0, w_len};
            r_invalid <= (w_icode > 4'hB);
          end
        end
      end
    end else if (pc_load) begin
      r_pc      <= pc_new;
      r_k       <= 4'd0;
      r_icode   <= 4'h0;
      r_ifun    <= 4'h0;
      r_ra      <= 4'hF;
      r_rb      <= 4'hF;
      r_valc    <= 64'd0;
      r_valp    <= pc_new;
      r_invalid <= 1'b0;
      r_err     <= 1'b0;
    end
  end

  // Request address depends only on registered state, never on mem_ack.
  assign mem_addr      = r_pc + {60'd0, r_k};
  assign mem_req       = (r_state == S_FETCH);
  assign instr_valid   = (r_state == S_DONE);
  assign pc_val        = r_pc;
  assign icode         = r_icode;
  assign ifun          = r_ifun;
  assign rA            = r_ra;
  assign rB            = r_rb;
  assign valC          = r_valc;
  assign valP          = r_valp;
  assign instr_invalid = r_invalid;
  assign imem_error    = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of instructions fetched from a
// byte-array memory model, plus fault/wait-state, stray pc_load and
// mid-fetch reset sequences.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] pc_new;
  logic        pc_load;
  logic [63:0] mem_addr;
  logic        mem_req;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        mem_err;
  logic [63:0] pc_val;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic        instr_valid, instr_invalid, imem_error;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [0:511];
  int          nwait = 0;
  int          wcnt  = 0;
  bit          err_en = 1'b0;
  logic [63:0] err_addr = 64'd0;

  fetch_unit #(.RESET_PC(64'h0)) dut (
    .clock(clock), .reset(reset), .pc_new(pc_new), .pc_load(pc_load),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_err(mem_err), .pc_val(pc_val),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .instr_valid(instr_valid), .instr_invalid(instr_invalid),
    .imem_error(imem_error)
  );

  always #5 clock = ~clock;

  // Memory model: ack after nwait wait cycles, optional fault at err_addr.
  assign mem_ack   = mem_req && (wcnt == nwait);
  assign mem_rdata = mem[mem_addr[8:0]];
  assign mem_err   = mem_ack && err_en && (mem_addr == err_addr);

  always @(posedge clock) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  typedef struct {
    logic [63:0] addr;
    logic [79:0] bytes;
    int          len;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        inv;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load_instr(input logic [63:0] a, input logic [79:0] b, input int len);
    logic [63:0] t;
    for (int i = 0; i < len; i++) begin
      t = a + 64'(i);
      mem[t[8:0]] = b[8*i +: 8];
    end
  endtask

  // Waits (bounded) for instr_valid; checks mem_addr = a + accepted bytes every
  // FETCH cycle, which also covers stability across wait states.
  task automatic wait_done(input logic [63:0] a, input bit stray,
                           output int cycles, output int acks, output bit addr_ok);
    cycles = 0; acks = 0; addr_ok = 1'b1;
    while (!instr_valid && cycles < 200) begin
      if (mem_addr !== a + 64'(acks)) addr_ok = 1'b0;
      if (mem_req && mem_ack) acks++;
      if (stray && cycles == 0) begin
        pc_new  = 64'h50;
        pc_load = 1'b1;
      end else begin
        pc_load = 1'b0;
      end
      cycles++;
      @(negedge clock);
    end
    pc_load = 1'b0;
  endtask

  task automatic run_fetch(input logic [63:0] a, input bit stray,
                           output int cycles, output int acks, output bit addr_ok);
    @(negedge clock);
    pc_new  = a;
    pc_load = 1'b1;
    @(negedge clock);
    pc_load = 1'b0;
    wait_done(a, stray, cycles, acks, addr_ok);
  endtask

  int cyc, acks, n;
  bit aok;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h10;

    vecs[0] = '{64'h0,   {64'h0807060504030201, 8'hF3, 8'h30}, 10, 4'h3, 4'h0, 4'hF, 4'h3, 64'h0807060504030201, 64'hA, 1'b0};
    vecs[1] = '{64'h100, {8'h00, 64'h40, 8'h73},                9, 4'h7, 4'h3, 4'hF, 4'hF, 64'h40, 64'h109, 1'b0};
    vecs[2] = '{64'h20,  80'hC0,                                1, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h21, 1'b1};
    vecs[3] = '{64'h30,  80'h1260,                              2, 4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h32, 1'b0};
    vecs[4] = '{64'h40,  {8'h00, 64'h1122334455667788, 8'h80},  9, 4'h8, 4'h0, 4'hF, 4'hF, 64'h1122334455667788, 64'h49, 1'b0};
    vecs[5] = '{64'h50,  80'h90,                                1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h51, 1'b0};
    vecs[6] = '{64'h60,  {64'hDEADBEEFCAFEF00D, 8'h45, 8'h50}, 10, 4'h5, 4'h0, 4'h4, 4'h5, 64'hDEADBEEFCAFEF00D, 64'h6A, 1'b0};
    vecs[7] = '{64'h70,  80'h00,                                1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h71, 1'b0};
    vecs[8] = '{64'h80,  80'hAB21,                              2, 4'h2, 4'h1, 4'hA, 4'hB, 64'h0, 64'h82, 1'b0};
    vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 80'h3461,              2, 4'h6, 4'h1, 4'h3, 4'h4, 64'h0, 64'h1, 1'b0};

    reset = 1'b1; pc_new = 64'd0; pc_load = 1'b0;
    @(negedge clock); @(negedge clock);
    chk("rst_mem_req", 64'(mem_req), 64'd1);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_rA_rB", {56'd0, rA, rB}, 64'hFF);
    chk("rst_icode", {56'd0, icode, ifun}, 64'h0);
    chk("rst_valP", valP, 64'h0);
    reset = 1'b0;

    // nop at 0 straight out of reset
    wait_done(64'h0, 1'b0, cyc, acks, aok);
    chk("nop_cycles", 64'(cyc), 64'd1);
    chk("nop_icode", 64'(icode), 64'h1);
    chk("nop_valP", valP, 64'h1);
    chk("nop_regs", {56'd0, rA, rB}, 64'hFF);

    for (int i = 0; i < 10; i++) begin
      load_instr(vecs[i].addr, vecs[i].bytes, vecs[i].len);
      run_fetch(vecs[i].addr, 1'b0, cyc, acks, aok);
      chk($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vecs[i].len));
      chk($sformatf("v%0d_acks", i), 64'(acks), 64'(vecs[i].len));
      chk($sformatf("v%0d_addr_seq", i), 64'(aok), 64'd1);
      chk($sformatf("v%0d_icode_ifun", i), {56'd0, icode, ifun}, {56'd0, vecs[i].icode, vecs[i].ifun});
      chk($sformatf("v%0d_rA_rB", i), {56'd0, rA, rB}, {56'd0, vecs[i].ra, vecs[i].rb});
      chk($sformatf("v%0d_valC", i), valC, vecs[i].valc);
      chk($sformatf("v%0d_valP", i), valP, vecs[i].valp);
      chk($sformatf("v%0d_pc_val", i), pc_val, vecs[i].addr);
      chk($sformatf("v%0d_invalid", i), 64'(instr_invalid), 64'(vecs[i].inv));
      chk($sformatf("v%0d_imem_err", i), 64'(imem_error), 64'd0);
    end

    // pc_load during FETCH must be ignored
    run_fetch(64'h30, 1'b1, cyc, acks, aok);
    chk("stray_pc_val", pc_val, 64'h30);
    chk("stray_valP", valP, 64'h32);
    chk("stray_cycles", 64'(cyc), 64'd2);
    chk("stray_valid", 64'(instr_valid), 64'd1);

    // Held in DONE indefinitely without pc_load
    repeat (5) @(negedge clock);
    chk("hold_valid", 64'(instr_valid), 64'd1);
    chk("hold_valP", valP, 64'h32);

    // rmmovq, fault on byte 3, two wait states per byte
    load_instr(64'h140, {64'h11111111111111AA, 8'h12, 8'h40}, 10);
    nwait = 2; err_en = 1'b1; err_addr = 64'h143;
    run_fetch(64'h140, 1'b0, cyc, acks, aok);
    nwait = 0; err_en = 1'b0;
    chk("err_cycles", 64'(cyc), 64'd12);
    chk("err_acks", 64'(acks), 64'd4);
    chk("err_addr_stable", 64'(aok), 64'd1);
    chk("err_flag", 64'(imem_error), 64'd1);
    chk("err_valP", valP, 64'h144);
    chk("err_icode", {56'd0, icode, ifun}, 64'h40);
    chk("err_regs", {56'd0, rA, rB}, 64'h12);
    chk("err_valC", valC, 64'hAA);
    chk("err_invalid", 64'(instr_invalid), 64'd0);

    // Reset during byte 5 of a call, then restart at 0
    load_instr(64'h0, {64'h0807060504030201, 8'hF3, 8'h30}, 10);
    load_instr(64'h180, {8'h00, 64'h1234, 8'h80}, 9);
    @(negedge clock);
    pc_new = 64'h180; pc_load = 1'b1;
    @(negedge clock);
    pc_load = 1'b0;
    n = 0; cyc = 0;
    while (n < 5 && cyc < 50) begin
      if (mem_req && mem_ack) n++;
      cyc++;
      @(negedge clock);
    end
    chk("rst_mid_reach", 64'(n), 64'd5);
    chk("rst_mid_addr_before", mem_addr, 64'h185);
    reset = 1'b1;
    #1;
    chk("rst_mid_req", 64'(mem_req), 64'd1);
    chk("rst_mid_addr", mem_addr, 64'h0);
    chk("rst_mid_valid", 64'(instr_valid), 64'd0);
    chk("rst_mid_pc", pc_val, 64'h0);
    @(negedge clock);
    reset = 1'b0;
    wait_done(64'h0, 1'b0, cyc, acks, aok);
    chk("rst_restart_cycles", 64'(cyc), 64'd10);
    chk("rst_restart_addr_seq", 64'(aok), 64'd1);
    chk("rst_restart_valC", valC, 64'h0807060504030201);
    chk("rst_restart_valP", valP, 64'hA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
